traffic_lights_xing: RTL and testbench



---
 rtl/traffic_lights_xing_pkg.sv | 36 +++
 rtl/traffic_lights_xing_blink_gen.sv | 37 +++
 rtl/traffic_lights_xing.sv | 246 ++++++++++++++++++++++++
 tb/tb_traffic_lights_xing.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_lights_xing_pkg.sv
// Shared types for the intersection controller: phase encoding, command codes
// and the ms-to-tick conversion used for both defaults and runtime commands.
package traffic_lights_pkg;

    typedef enum logic [2:0] {
        ST_OFF          = 3'd0,
        ST_YELLOW_BLINK = 3'd1,
        ST_ALL_RED      = 3'd2,
        ST_RED_YELLOW   = 3'd3,
        ST_GREEN        = 3'd4,
        ST_GREEN_BLINK  = 3'd5,
        ST_YELLOW       = 3'd6
    } state_e;

    localparam logic [2:0] CMD_ON             = 3'd0;
    localparam logic [2:0] CMD_OFF            = 3'd1;
    localparam logic [2:0] CMD_BLINK          = 3'd2;
    localparam logic [2:0] CMD_SET_GREEN      = 3'd3;
    localparam logic [2:0] CMD_SET_YELLOW     = 3'd4;
    localparam logic [2:0] CMD_SET_ALL_RED    = 3'd5;
    localparam logic [2:0] CMD_SET_RED_YELLOW = 3'd6;

    // Saturates at the largest value a w-bit timer can hold.
    function automatic logic [31:0] ms_to_ticks(input logic [31:0] ms,
                                                input int clk_hz,
                                                input int w);
        logic [31:0] prod;
        logic [31:0] ticks;
        logic [31:0] lim;
        prod  = ms * $unsigned(clk_hz);
        ticks = prod / 32'd1000;
        lim   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (ticks > lim) ? lim : ticks;
    endfunction

endpackage

// File: rtl/traffic_lights_xing_blink_gen.sv
// Blink phase generator: lit for `half` cycles, dark for `half` cycles,
// phase 0 on the first cycle of any blinking state.
module blink_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk_0m002,
    input  logic             arst_i,
    input  logic             en,
    input  logic             restart,
    input  logic [CNT_W-1:0] half,
    output logic             lamp_on
);

    localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

    logic [CNT_W:0] cnt;
    logic [CNT_W:0] phase;
    logic [CNT_W:0] wrap_at;

    // restart forces phase 0 even when one blinking state hands over to the other
    assign phase   = restart ? '0 : cnt;
    assign wrap_at = {half, 1'b0} - ONE;
    assign lamp_on = en && (phase < {1'b0, half});

    always_ff @(posedge clk_0m002 or posedge arst_i) begin
        if (arst_i) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (phase >= wrap_at) begin
            cnt <= '0;
        end else begin
            cnt <= phase + ONE;
        end
    end

endmodule

// File: rtl/traffic_lights_xing.sv
// Multi-channel intersection controller: round-robin green with all-red
// clearance, programmable per-channel green/yellow, shared blink generator.
//
// state           | meaning
// ST_OFF          | all lamps dark
// ST_YELLOW_BLINK | every yellow blinks; only state accepting configuration
// ST_ALL_RED      | clearance, every channel red
// ST_RED_YELLOW   | active channel red+yellow, others red
// ST_GREEN        | active channel green, others red
// ST_GREEN_BLINK  | active channel green blinking, others red
// ST_YELLOW       | active channel yellow, others red
module traffic_lights_xing
    import traffic_lights_pkg::*;
#(
    parameter int CHANNELS              = 2,
    parameter int CLK_FREQ_HZ           = 2000,
    parameter int TIMER_W               = 16,
    parameter int BLINK_HALF_PERIOD_MS  = 250,
    parameter int BLINK_COUNT           = 3,
    parameter int GREEN_MS_DEFAULT      = 10000,
    parameter int YELLOW_MS_DEFAULT     = 3000,
    parameter int ALL_RED_MS_DEFAULT    = 1000,
    parameter int RED_YELLOW_MS_DEFAULT = 2000
) (
    input  logic                        clk_0m002,
    input  logic                        arst_i,
    input  logic                        cmd_val_i,
    input  logic [2:0]                  cmd_type_i,
    input  logic [$clog2(CHANNELS)-1:0] cmd_chan_i,
    input  logic [15:0]                 cmd_data_i,
    output logic [CHANNELS-1:0]         red_o,
    output logic [CHANNELS-1:0]         yellow_o,
    output logic [CHANNELS-1:0]         green_o,
    output logic [2:0]                  mode_o,
    output logic [$clog2(CHANNELS)-1:0] active_ch_o
);

    localparam int CH_W = $clog2(CHANNELS);

    localparam logic [31:0] GREEN_D32  = ms_to_ticks(32'(GREEN_MS_DEFAULT), CLK_FREQ_HZ, TIMER_W);
    localparam logic [31:0] YELLOW_D32 = ms_to_ticks(32'(YELLOW_MS_DEFAULT), CLK_FREQ_HZ, TIMER_W);
    localparam logic [31:0] ALLRED_D32 = ms_to_ticks(32'(ALL_RED_MS_DEFAULT), CLK_FREQ_HZ, TIMER_W);
    localparam logic [31:0] RY_D32     = ms_to_ticks(32'(RED_YELLOW_MS_DEFAULT), CLK_FREQ_HZ, TIMER_W);
    localparam logic [31:0] HALF_D32   = ms_to_ticks(32'(BLINK_HALF_PERIOD_MS), CLK_FREQ_HZ, TIMER_W);
    localparam logic [31:0] BLINK_D32  = 32'd2 * HALF_D32 * 32'(BLINK_COUNT);

    localparam logic [TIMER_W-1:0] GREEN_DEF      = GREEN_D32[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] YELLOW_DEF     = YELLOW_D32[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] ALL_RED_DEF    = ALLRED_D32[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] RED_YELLOW_DEF = RY_D32[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] BLINK_HALF_CLK = HALF_D32[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] BLINK_DUR      = BLINK_D32[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] ONE_T          = {{(TIMER_W-1){1'b0}}, 1'b1};

    state_e             state;
    logic [CH_W-1:0]    active_ch;
    logic [TIMER_W-1:0] timer;
    logic               state_first;
    logic [TIMER_W-1:0] green_t  [CHANNELS];
    logic [TIMER_W-1:0] yellow_t [CHANNELS];
    logic [TIMER_W-1:0] all_red_t;
    logic [TIMER_W-1:0] red_yellow_t;

    logic [31:0]         cmd_t32;
    logic [TIMER_W-1:0]  cmd_ticks;
    logic                mode_cmd;
    logic                chan_ok;
    logic                running;
    logic [TIMER_W-1:0]  dur;
    logic                phase_done;
    logic [CH_W-1:0]     nxt_ch;
    logic                any_en;
    int                  idx;
    logic [CH_W-1:0]     idx_c;
    logic                blink_en;
    logic                blink_on;
    logic [CHANNELS-1:0] act_oh;
    logic [CHANNELS-1:0] red_c;
    logic [CHANNELS-1:0] yel_c;
    logic [CHANNELS-1:0] grn_c;

    assign cmd_t32   = ms_to_ticks({16'd0, cmd_data_i}, CLK_FREQ_HZ, TIMER_W);
    assign cmd_ticks = cmd_t32[TIMER_W-1:0];
    assign mode_cmd  = cmd_val_i && (cmd_type_i == CMD_ON || cmd_type_i == CMD_OFF ||
                                     cmd_type_i == CMD_BLINK);
    assign chan_ok   = 32'(cmd_chan_i) < 32'(CHANNELS);
    assign running   = (state == ST_ALL_RED) || (state == ST_RED_YELLOW) || (state == ST_GREEN) ||
                       (state == ST_GREEN_BLINK) || (state == ST_YELLOW);

    always_comb begin
        dur = '0;
        case (state)
            ST_ALL_RED:     dur = all_red_t;
            ST_RED_YELLOW:  dur = red_yellow_t;
            ST_GREEN:       dur = green_t[active_ch];
            ST_GREEN_BLINK: dur = BLINK_DUR;
            ST_YELLOW:      dur = yellow_t[active_ch];
            default:        dur = '0;
        endcase
    end

    // a zero duration still occupies one cycle
    assign phase_done = (dur <= ONE_T) || (timer == dur - ONE_T);

    // nearest enabled channel after active_ch, wrapping round to active_ch itself last
    always_comb begin
        nxt_ch = active_ch;
        any_en = 1'b0;
        idx    = 0;
        idx_c  = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx   = (int'(active_ch) + k) % CHANNELS;
            idx_c = idx[CH_W-1:0];
            if (green_t[idx_c] != '0) begin
                nxt_ch = idx_c;
                any_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_0m002 or posedge arst_i) begin
        if (arst_i) begin
            state        <= ST_OFF;
            active_ch    <= '0;
            timer        <= '0;
            state_first  <= 1'b1;
            all_red_t    <= ALL_RED_DEF;
            red_yellow_t <= RED_YELLOW_DEF;
            for (int i = 0; i < CHANNELS; i++) begin
                green_t[i]  <= GREEN_DEF;
                yellow_t[i] <= YELLOW_DEF;
            end
        end else begin
            state_first <= 1'b0;
            if (mode_cmd) begin
                timer <= '0;
                case (cmd_type_i)
                    CMD_ON: begin
                        state       <= ST_ALL_RED;
                        active_ch   <= '0;
                        state_first <= 1'b1;
                    end
                    CMD_OFF: begin
                        state       <= ST_OFF;
                        state_first <= (state != ST_OFF);
                    end
                    default: begin
                        state       <= ST_YELLOW_BLINK;
                        state_first <= (state != ST_YELLOW_BLINK);
                    end
                endcase
            end else begin
                if (cmd_val_i && state == ST_YELLOW_BLINK) begin
                    case (cmd_type_i)
                        CMD_SET_GREEN:      if (chan_ok) green_t[cmd_chan_i] <= cmd_ticks;
                        CMD_SET_YELLOW:     if (chan_ok) yellow_t[cmd_chan_i] <= cmd_ticks;
                        CMD_SET_ALL_RED:    all_red_t <= cmd_ticks;
                        CMD_SET_RED_YELLOW: red_yellow_t <= cmd_ticks;
                        default: ;
                    endcase
                end
                if (running) begin
                    timer <= timer + ONE_T;
                    if (phase_done) begin
                        timer       <= '0;
                        state_first <= 1'b1;
                        case (state)
                            ST_ALL_RED: begin
                                if (green_t[active_ch] != '0) begin
                                    state <= ST_RED_YELLOW;
                                end else if (any_en) begin
                                    active_ch <= nxt_ch;
                                    state     <= ST_RED_YELLOW;
                                end else begin
                                    state_first <= 1'b0;
                                end
                            end
                            ST_RED_YELLOW:  state <= ST_GREEN;
                            ST_GREEN:       state <= ST_GREEN_BLINK;
                            ST_GREEN_BLINK: state <= ST_YELLOW;
                            ST_YELLOW: begin
                                state <= ST_ALL_RED;
                                if (any_en) active_ch <= nxt_ch;
                            end
                            default: state <= ST_OFF;
                        endcase
                    end
                end
            end
        end
    end

    assign blink_en = (state == ST_GREEN_BLINK) || (state == ST_YELLOW_BLINK);

    blink_gen #(
        .CNT_W (TIMER_W)
    ) u_blink (
        .clk_0m002 (clk_0m002),
        .arst_i    (arst_i),
        .en        (blink_en),
        .restart   (state_first),
        .half      (BLINK_HALF_CLK),
        .lamp_on   (blink_on)
    );

    always_comb begin
        act_oh = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            act_oh[i] = (active_ch == CH_W'(i));
        end
    end

    always_comb begin
        red_c = '0;
        yel_c = '0;
        grn_c = '0;
        case (state)
            ST_YELLOW_BLINK: yel_c = {CHANNELS{blink_on}};
            ST_ALL_RED:      red_c = '1;
            ST_RED_YELLOW: begin
                red_c = '1;
                yel_c = act_oh;
            end
            ST_GREEN: begin
                red_c = ~act_oh;
                grn_c = act_oh;
            end
            ST_GREEN_BLINK: begin
                red_c = ~act_oh;
                grn_c = blink_on ? act_oh : '0;
            end
            ST_YELLOW: begin
                red_c = ~act_oh;
                yel_c = act_oh;
            end
            default: ;
        endcase
    end

    assign red_o       = red_c;
    assign yellow_o    = yel_c;
    assign green_o     = grn_c;
    assign mode_o      = state;
    assign active_ch_o = active_ch;

endmodule

// File: tb/tb_traffic_lights_xing.sv
// Directed bench for traffic_lights_xing with three channels and default timing.
module tb_traffic_lights_xing;
    import traffic_lights_pkg::*;

    localparam int HALF = 500;   // 250 ms at 2 kHz

    logic       clk_0m002 = 1'b0;
    logic       arst_i = 1'b1;
    logic       cmd_val_i = 1'b0;
    logic [2:0] cmd_type_i = 3'd0;
    logic [1:0] cmd_chan_i = 2'd0;
    logic [15:0] cmd_data_i = 16'd0;
    logic [2:0] red_o;
    logic [2:0] yellow_o;
    logic [2:0] green_o;
    logic [2:0] mode_o;
    logic [1:0] active_ch_o;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ch1_bad = 0;
    logic watch_ch1 = 1'b0;

    typedef struct {
        string      name;
        logic [2:0] st;
        int         len;
        logic [2:0] red;
        logic [2:0] yel;
        logic [2:0] grn;
        logic [1:0] act;
        bit         blink;
        int         inj_at;
        logic [2:0] inj_type;
    } phase_t;

    typedef struct {
        logic [31:0] ms;
        int          ticks;
    } conv_t;

    phase_t ph_a [5];
    phase_t ph_b [13];
    conv_t  conv [6];

    traffic_lights_xing #(
        .CHANNELS (3)
    ) dut (
        .clk_0m002   (clk_0m002),
        .arst_i      (arst_i),
        .cmd_val_i   (cmd_val_i),
        .cmd_type_i  (cmd_type_i),
        .cmd_chan_i  (cmd_chan_i),
        .cmd_data_i  (cmd_data_i),
        .red_o       (red_o),
        .yellow_o    (yellow_o),
        .green_o     (green_o),
        .mode_o      (mode_o),
        .active_ch_o (active_ch_o)
    );

    always #5 clk_0m002 = ~clk_0m002;

    always @(negedge clk_0m002) begin
        if (watch_ch1 && mode_o >= 3'd2 && red_o[1] !== 1'b1) ch1_bad++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 3000000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] t, input logic [1:0] c, input logic [15:0] d);
        cmd_type_i = t;
        cmd_chan_i = c;
        cmd_data_i = d;
        cmd_val_i  = 1'b1;
        @(negedge clk_0m002);
        cmd_val_i  = 1'b0;
    endtask

    function automatic phase_t mk(input string name, input logic [2:0] st, input int len,
                                  input logic [2:0] red, input logic [2:0] yel,
                                  input logic [2:0] grn, input logic [1:0] act,
                                  input bit blink, input int inj_at, input logic [2:0] inj_type);
        phase_t p;
        p.name = name; p.st = st; p.len = len; p.red = red; p.yel = yel; p.grn = grn;
        p.act = act; p.blink = blink; p.inj_at = inj_at; p.inj_type = inj_type;
        return p;
    endfunction

    // Entered at the negedge of the first cycle of the phase; leaves at the first cycle after it.
    task automatic do_phase(input phase_t p);
        int n;
        int bad;
        logic [2:0] eg;
        n   = 0;
        bad = 0;
        check({p.name, "_mode"}, mode_o, p.st);
        check({p.name, "_red"}, red_o, p.red);
        check({p.name, "_yellow"}, yellow_o, p.yel);
        check({p.name, "_green"}, green_o, p.grn);
        check({p.name, "_active"}, active_ch_o, p.act);
        while (mode_o == p.st && n < p.len + 10) begin
            if (p.blink) begin
                eg = ((n % (2 * HALF)) < HALF) ? p.grn : 3'b000;
                if (green_o != eg || red_o != p.red || yellow_o != 3'b000) bad++;
            end
            n++;
            if (n == p.inj_at) begin
                cmd_type_i = p.inj_type;
                cmd_chan_i = 2'd0;
                cmd_data_i = 16'd1;
                cmd_val_i  = 1'b1;
            end else begin
                cmd_val_i = 1'b0;
            end
            @(negedge clk_0m002);
        end
        cmd_val_i = 1'b0;
        check({p.name, "_len"}, n, p.len);
        if (p.blink) check({p.name, "_pattern_errs"}, bad, 0);
    endtask

    initial begin
        int tmp;
        int w;
        int bad;

        conv[0] = '{32'hFFFF, 65535};
        conv[1] = '{32'd32768, 65535};
        conv[2] = '{32'd32767, 65534};
        conv[3] = '{32'd5, 10};
        conv[4] = '{32'd1, 2};
        conv[5] = '{32'd0, 0};

        ph_a[0] = mk("a_allred", ST_ALL_RED,     2000,  3'b111, 3'b000, 3'b000, 2'd0, 0, 0, 3'd0);
        ph_a[1] = mk("a_redyel", ST_RED_YELLOW,  4000,  3'b111, 3'b001, 3'b000, 2'd0, 0, 10, 3'd7);
        ph_a[2] = mk("a_green",  ST_GREEN,       20000, 3'b110, 3'b000, 3'b001, 2'd0, 0, 100, CMD_SET_GREEN);
        ph_a[3] = mk("a_gblink", ST_GREEN_BLINK, 3000,  3'b110, 3'b000, 3'b001, 2'd0, 1, 0, 3'd0);
        ph_a[4] = mk("a_yellow", ST_YELLOW,      6000,  3'b110, 3'b001, 3'b000, 2'd0, 0, 0, 3'd0);

        ph_b[0]  = mk("b_allred0", ST_ALL_RED,     1,    3'b111, 3'b000, 3'b000, 2'd0, 0, 0, 3'd0);
        ph_b[1]  = mk("b_redyel0", ST_RED_YELLOW,  1,    3'b111, 3'b001, 3'b000, 2'd0, 0, 0, 3'd0);
        ph_b[2]  = mk("b_green0",  ST_GREEN,       10,   3'b110, 3'b000, 3'b001, 2'd0, 0, 0, 3'd0);
        ph_b[3]  = mk("b_gblink0", ST_GREEN_BLINK, 3000, 3'b110, 3'b000, 3'b001, 2'd0, 1, 0, 3'd0);
        ph_b[4]  = mk("b_yellow0", ST_YELLOW,      2,    3'b110, 3'b001, 3'b000, 2'd0, 0, 0, 3'd0);
        ph_b[5]  = mk("b_allred2", ST_ALL_RED,     1,    3'b111, 3'b000, 3'b000, 2'd2, 0, 0, 3'd0);
        ph_b[6]  = mk("b_redyel2", ST_RED_YELLOW,  1,    3'b111, 3'b100, 3'b000, 2'd2, 0, 0, 3'd0);
        ph_b[7]  = mk("b_green2",  ST_GREEN,       10,   3'b011, 3'b000, 3'b100, 2'd2, 0, 0, 3'd0);
        ph_b[8]  = mk("b_gblink2", ST_GREEN_BLINK, 3000, 3'b011, 3'b000, 3'b100, 2'd2, 1, 0, 3'd0);
        ph_b[9]  = mk("b_yellow2", ST_YELLOW,      2,    3'b011, 3'b100, 3'b000, 2'd2, 0, 0, 3'd0);
        ph_b[10] = mk("b_allred3", ST_ALL_RED,     1,    3'b111, 3'b000, 3'b000, 2'd0, 0, 0, 3'd0);
        ph_b[11] = mk("b_redyel3", ST_RED_YELLOW,  1,    3'b111, 3'b001, 3'b000, 2'd0, 0, 0, 3'd0);
        ph_b[12] = mk("b_green3",  ST_GREEN,       5,    3'b110, 3'b000, 3'b001, 2'd0, 0, 5, CMD_OFF);

        for (int i = 0; i < 6; i++) begin
            tmp = int'(ms_to_ticks(conv[i].ms, 2000, 16));
            check($sformatf("conv_%0d", conv[i].ms), tmp, conv[i].ticks);
        end

        repeat (3) @(negedge clk_0m002);
        arst_i = 1'b0;
        @(negedge clk_0m002);
        check("rst_mode", mode_o, ST_OFF);
        check("rst_lamps", {red_o, yellow_o, green_o}, 0);
        check("rst_active", active_ch_o, 0);

        // default timing, commands outside YELLOW_BLINK ignored
        send(CMD_ON, 2'd0, 16'd0);
        for (int i = 0; i < 5; i++) do_phase(ph_a[i]);
        check("a_wrap_mode", mode_o, ST_ALL_RED);
        check("a_wrap_active", active_ch_o, 1);
        check("a_wrap_red", red_o, 3'b111);

        send(CMD_BLINK, 2'd0, 16'd0);
        check("yb_mode", mode_o, ST_YELLOW_BLINK);
        check("yb_first", {red_o, yellow_o, green_o}, 9'b000_111_000);
        repeat (HALF - 1) @(negedge clk_0m002);
        check("yb_lit_end", yellow_o, 3'b111);
        @(negedge clk_0m002);
        check("yb_dark", yellow_o, 3'b000);

        send(CMD_SET_GREEN, 2'd0, 16'd5);
        send(CMD_SET_YELLOW, 2'd0, 16'd1);
        send(CMD_SET_ALL_RED, 2'd0, 16'd0);
        send(CMD_SET_RED_YELLOW, 2'd0, 16'd0);
        send(CMD_SET_GREEN, 2'd1, 16'd0);
        send(CMD_SET_GREEN, 2'd2, 16'd5);
        send(CMD_SET_YELLOW, 2'd2, 16'd1);
        send(CMD_SET_GREEN, 2'd3, 16'd0);
        send(CMD_ON, 2'd0, 16'd0);
        watch_ch1 = 1'b1;
        for (int i = 0; i < 13; i++) do_phase(ph_b[i]);
        watch_ch1 = 1'b0;
        check("off_mode", mode_o, ST_OFF);
        check("off_lamps", {red_o, yellow_o, green_o}, 0);
        check("ch1_red_errs", ch1_bad, 0);

        // disabled active channel is skipped on ALL_RED exit
        send(CMD_BLINK, 2'd0, 16'd0);
        send(CMD_SET_GREEN, 2'd0, 16'd0);
        send(CMD_ON, 2'd0, 16'd0);
        check("skip_allred_active", active_ch_o, 0);
        @(negedge clk_0m002);
        check("skip_mode", mode_o, ST_RED_YELLOW);
        check("skip_active", active_ch_o, 2);
        check("skip_yellow", yellow_o, 3'b100);

        send(CMD_BLINK, 2'd0, 16'd0);
        send(CMD_SET_GREEN, 2'd2, 16'd0);
        send(CMD_ON, 2'd0, 16'd0);
        send(CMD_SET_GREEN, 2'd2, 16'd5);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (mode_o != ST_ALL_RED || red_o != 3'b111 || active_ch_o != 2'd0) bad++;
            @(negedge clk_0m002);
        end
        check("stuck_allred_errs", bad, 0);

        // async reset mid-YELLOW restores defaults
        send(CMD_BLINK, 2'd0, 16'd0);
        send(CMD_SET_GREEN, 2'd0, 16'd5);
        send(CMD_SET_YELLOW, 2'd0, 16'd10);
        send(CMD_ON, 2'd0, 16'd0);
        w = 0;
        while (mode_o != ST_YELLOW && w < 5000) begin
            @(negedge clk_0m002);
            w++;
        end
        check("reach_yellow", mode_o, ST_YELLOW);
        repeat (5) @(negedge clk_0m002);
        check("pre_rst_yellow", yellow_o, 3'b001);
        #2 arst_i = 1'b1;
        #1;
        check("arst_mode", mode_o, ST_OFF);
        check("arst_lamps", {red_o, yellow_o, green_o}, 0);
        @(negedge clk_0m002);
        arst_i = 1'b0;
        @(negedge clk_0m002);
        send(CMD_ON, 2'd0, 16'd0);
        do_phase(ph_a[0]);
        do_phase(ph_a[1]);
        check("post_rst_green", mode_o, ST_GREEN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
